// File: rtl/mem_req_frontend_pkg.sv
// Shared constants and types for the memory-arbiter request front end.
package mem_arb_pkg;

    localparam int unsigned M1 = 0;
    localparam int unsigned M2 = 1;
    localparam int unsigned M3 = 2;

    localparam logic [1:0] ACC_NONE = 2'b00;
    localparam logic [1:0] ACC_M1   = 2'b01;
    localparam logic [1:0] ACC_M2   = 2'b10;
    localparam logic [1:0] ACC_M3   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        PEND   = 2'b01,
        ACTIVE = 2'b10
    } chan_state_t;

endpackage

// File: rtl/mem_req_frontend_if.sv
// Start/grant/request bundle between the masters, the front end and the arbiter.
interface mem_req_frontend_if #(
    parameter int unsigned LEN_W = 4
);
    logic [2:0]         start;
    logic [3*LEN_W-1:0] len;
    logic [1:0]         accmodule;
    logic [2:0]         start_ready;
    logic [2:0]         req;
    logic [2:0]         done;
    logic [2:0]         beat;
    logic [2:0]         timeout;

    modport master (
        output start, len, accmodule,
        input  start_ready, req, done, beat, timeout
    );

    modport slave (
        input  start, len, accmodule,
        output start_ready, req, done, beat, timeout
    );
endinterface

// File: rtl/mem_req_frontend_chan.sv
// One master's request channel: burst latch, beat countdown and starvation watch.
module mem_req_chan
    import mem_arb_pkg::*;
#(
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned MAX_WAIT = 15,
    parameter logic [1:0]  CODE     = ACC_M1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [1:0]       acc_i,
    output logic             start_ready_o,
    output logic             req_o,
    output logic             done_o,
    output logic             beat_o,
    output logic             timeout_o
);
    localparam int unsigned      WaitW   = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);
    localparam logic [LEN_W-1:0] LenOne  = LEN_W'(1);

    chan_state_t      state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             timeout_q, timeout_d;

    assign start_ready_o = (state_q == IDLE);
    assign req_o         = (state_q != IDLE);
    assign beat_o        = req_o && (acc_i == CODE);
    assign done_o        = beat_o && (rem_q == LenOne);
    assign timeout_o     = timeout_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    // A zero length is treated as a single-beat burst.
                    rem_d     = (len_i == '0) ? LenOne : len_i;
                    wait_d    = '0;
                    timeout_d = 1'b0;
                    state_d   = PEND;
                end
            end
            PEND, ACTIVE: begin
                if (beat_o) begin
                    rem_d   = rem_q - LenOne;
                    wait_d  = '0;
                    state_d = (rem_q == LenOne) ? IDLE : ACTIVE;
                end else begin
                    if (wait_q != WaitMax) wait_d = wait_q + 1'b1;
                    if (wait_d == WaitMax) timeout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end
endmodule

// File: rtl/mem_req_frontend.sv
// Three independent request channels feeding the three-master memory arbiter.
module mem_req_frontend
    import mem_arb_pkg::*;
#(
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    mem_req_frontend_if.slave bus
);
    mem_req_chan #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT), .CODE(ACC_M1)) u_chan_m1 (
        .clk           (clk),
        .reset         (reset),
        .start_i       (bus.start[M1]),
        .len_i         (bus.len[M1*LEN_W +: LEN_W]),
        .acc_i         (bus.accmodule),
        .start_ready_o (bus.start_ready[M1]),
        .req_o         (bus.req[M1]),
        .done_o        (bus.done[M1]),
        .beat_o        (bus.beat[M1]),
        .timeout_o     (bus.timeout[M1])
    );

    mem_req_chan #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT), .CODE(ACC_M2)) u_chan_m2 (
        .clk           (clk),
        .reset         (reset),
        .start_i       (bus.start[M2]),
        .len_i         (bus.len[M2*LEN_W +: LEN_W]),
        .acc_i         (bus.accmodule),
        .start_ready_o (bus.start_ready[M2]),
        .req_o         (bus.req[M2]),
        .done_o        (bus.done[M2]),
        .beat_o        (bus.beat[M2]),
        .timeout_o     (bus.timeout[M2])
    );

    mem_req_chan #(.LEN_W(LEN_W), .MAX_WAIT(MAX_WAIT), .CODE(ACC_M3)) u_chan_m3 (
        .clk           (clk),
        .reset         (reset),
        .start_i       (bus.start[M3]),
        .len_i         (bus.len[M3*LEN_W +: LEN_W]),
        .acc_i         (bus.accmodule),
        .start_ready_o (bus.start_ready[M3]),
        .req_o         (bus.req[M3]),
        .done_o        (bus.done[M3]),
        .beat_o        (bus.beat[M3]),
        .timeout_o     (bus.timeout[M3])
    );
endmodule

// File: doc/mem_req_frontend.md
# mem_req_frontend

Per-master request front end for the three-master memory arbiter. It turns one-cycle `start` pulses carrying a burst length into held `req` lines toward the arbiter. It counts granted beats from the arbiter's `accmodule` feedback and drives `done` on the final beat. It also flags masters that wait too long for a grant. It sits directly upstream of the arbiter, which consumes its `req` and `done` outputs.

## Interface
- `LEN_W`, default 4: burst-length width; a burst is 1 to 2^LEN_W-1 beats.
- `MAX_WAIT`, default 15: number of consecutive ungranted cycles with `req` high that sets `timeout`.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: asynchronous, active-low (asserted at 0).
- `start`, input, 3: one-cycle request pulse per master; bit 0 = M1, bit 1 = M2, bit 2 = M3.
- `len`, input, 3*LEN_W: burst length per master; slice i is sampled together with `start[i]`.
- `accmodule`, input, 2: arbiter grant code; 00 = none, 01 = M1, 10 = M2, 11 = M3.
- `start_ready`, output, 3: master i is idle and can accept `start[i]`.
- `req`, output, 3: held request to the arbiter (registered).
- `done`, output, 3: master i's final beat is in progress this cycle (combinational from registered state and `accmodule`).
- `beat`, output, 3: master i is granted this cycle and a burst is active.
- `timeout`, output, 3: sticky starvation flag per master.

## Operation
- Each master runs an independent channel FSM with three states: IDLE, PEND and ACTIVE.
- **IDLE**
  - `start_ready[i]`=1 and `req[i]`=0.
  - On `start[i]`=1: latch `len` slice i into `rem`; a value of 0 is stored as 1.
  - Clear `wait_cnt` and `timeout[i]`, then go to PEND.
- **PEND**
  - `req[i]`=1.
  - If `accmodule` equals code(i), the cycle is a beat and the channel goes to ACTIVE.
  - The beat behaves exactly as it would in ACTIVE: `rem` decrements, and if `rem`==1, `done[i]`=1 and the next state is IDLE.
- **ACTIVE**
  - `req[i]`=1.
  - Every cycle with `accmodule`==code(i) is a beat: `beat[i]`=1 and `rem` decrements.
  - On a beat with `rem`==1: `done[i]`=1 and the next state is IDLE, so `req[i]` drops the following cycle.
- **Grant loss** (M1 interrupting M2/M3, or the arbiter's two-cycle limit ending the access without `done`):
  - The channel stays ACTIVE with `req` high and `rem` held.
  - Beats resume on the next grant.
- **Wait counter**
  - `wait_cnt` increments on every cycle with `req[i]`=1 and no grant to master i, and saturates at `MAX_WAIT`.
  - It resets to 0 on any beat.
  - `timeout[i]` sets when `wait_cnt` reaches `MAX_WAIT` and stays set until the next accepted `start[i]`.
- **Start while busy:** `start[i]` in PEND or ACTIVE is ignored, with no error.
- **`accmodule`==00:** never a beat; if it shows the code of a master not requesting, the grant is ignored for that master.
- **Reset:** all channels return to IDLE immediately. `req`, `done`, `beat` and `timeout` go to 0, `start_ready`=3'b111, and counters clear, including mid-burst.

## Timing
- `start[i]` sampled at edge t gives `req[i]`=1 from cycle t+1.
- Grant first seen in cycle g with length L and no interruption:
  - `beat[i]` is high for cycles g..g+L-1.
  - `done[i]` is high in cycle g+L-1 only.
  - `req[i]`=0 and `start_ready[i]`=1 from cycle g+L.
- The earliest restart is a `start` in cycle g+L, which gives `req` again at g+L+1. There is always at least one cycle of `req` low between bursts.
- `done` and `beat` depend combinationally on `accmodule`; there is no combinational path from `start` to any output.
- Channels are fully independent; simultaneous starts on all three are accepted in the same cycle.

## Structure
- Package `mem_arb_pkg` contains:
  - master index constants `M1`=0, `M2`=1, `M3`=2;
  - grant codes `ACC_NONE`, `ACC_M1`, `ACC_M2`, `ACC_M3`;
  - channel state enum `chan_state_t` (IDLE, PEND, ACTIVE).
- Sub-module `mem_req_chan` holds one channel's FSM, `rem` and `wait_cnt`, and takes its grant code as a parameter. The top instantiates it three times.

## Test plan
- **Single burst:** reset, then `start`=001 with len[M1]=3 and `accmodule`=01 from the cycle after `req[0]` rises. Expect `beat[0]` for 3 cycles, `done[0]` in the 3rd, and `req[0]`=0 on the next cycle.
- **Interrupted burst:** M2 len=4; grant 10 for 2 cycles, then 01 for 3 cycles, then 10 for 2 cycles. Expect `req[1]` high throughout, `done[1]` only in the final 10 cycle, and 4 total beats.
- **Length 0:** len[M3]=0 with grant 11. Expect `done[2]` in the first grant cycle, equivalent to len=1.
- **Starvation:** M3 pending with `accmodule`=00 for 15 cycles. Expect `timeout[2]`=1 at the 15th cycle, still 1 after the burst completes, and cleared by the next `start[2]`.
- **Start while busy:** `start[0]` pulsed during an active M1 burst. Expect it ignored and `rem` unchanged.
- **Reset mid-burst:** assert `reset`=0 during M2 ACTIVE. Expect `req`=000, `done`=000, `start_ready`=111 immediately, and no stale `done` after `reset` is released.
